// File: rtl/pace_emitter_if.sv
// pace_emitter_if -- request/status bundle for the pace emitter.
//   tick_i       : one-clk timebase strobe (slow rate)
//   enable_i     : 1 = pace requests accepted
//   pace_req_i   : pace request, rising edge significant
//   pace_o       : widened pace pulse
//   busy_o       : high while pulsing or blanking
//   dropped_o    : one-clk strobe for a rejected request edge
//   pace_count_o : number of paces emitted (wraps)
// master = request source / observer, slave = pace_emitter.
interface pace_emitter_if;
    logic        tick_i;
    logic        enable_i;
    logic        pace_req_i;
    logic        pace_o;
    logic        busy_o;
    logic        dropped_o;
    logic [15:0] pace_count_o;

    modport master (
        output tick_i, enable_i, pace_req_i,
        input  pace_o, busy_o, dropped_o, pace_count_o
    );

    modport slave (
        input  tick_i, enable_i, pace_req_i,
        output pace_o, busy_o, dropped_o, pace_count_o
    );
endinterface

// File: rtl/pace_emitter.sv
// pace_emitter -- turns a request edge into a pace pulse WIDTH_TICKS timebase
// strobes long, followed by BLANK_TICKS strobes of refractory blanking.
// Request edges arriving while pulsing or blanking are rejected and flagged.
//   clk : single clock
//   rst : asynchronous active-high reset
//   bus : pace_emitter_if.slave (tick/enable/request in, pace/busy/dropped/count out)
module pace_emitter #(
    parameter int unsigned WIDTH_TICKS = 15,
    parameter int unsigned BLANK_TICKS = 150
) (
    input logic           clk,
    input logic           rst,
    pace_emitter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PULSE, BLANK} state_t;

    // Terminal tick counts; BLANK_LAST is unused when BLANK_TICKS == 0.
    localparam logic [15:0] WIDTH_LAST = 16'(WIDTH_TICKS - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_TICKS - 1);

    state_t      state;
    logic [15:0] tcnt;
    logic        req_prev;
    logic        req_rise;
    logic        pace_q;
    logic        busy_q;
    logic        dropped_q;
    logic [15:0] pace_count_q;

    // req_prev resets high so a request held through reset must be
    // released and reasserted before it can pace.
    assign req_rise = ~req_prev & bus.pace_req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tcnt         <= '0;
            req_prev     <= 1'b1;
            pace_q       <= 1'b0;
            busy_q       <= 1'b0;
            dropped_q    <= 1'b0;
            pace_count_q <= '0;
        end else begin
            req_prev  <= bus.pace_req_i;
            dropped_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A tick coinciding with acceptance is not counted.
                    if (req_rise && bus.enable_i) begin
                        state        <= PULSE;
                        tcnt         <= '0;
                        pace_count_q <= pace_count_q + 16'd1;
                        pace_q       <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                PULSE: begin
                    dropped_q <= req_rise;
                    if (bus.tick_i) begin
                        if (tcnt == WIDTH_LAST) begin
                            tcnt   <= '0;
                            pace_q <= 1'b0;
                            if (BLANK_TICKS == 0) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state  <= BLANK;
                            end
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                end
                BLANK: begin
                    // An edge on the exit clk is still rejected.
                    dropped_q <= req_rise;
                    if (bus.tick_i) begin
                        if (tcnt == BLANK_LAST) begin
                            state  <= IDLE;
                            tcnt   <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tcnt   <= '0;
                    pace_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pace_o       = pace_q;
    assign bus.busy_o       = busy_q;
    assign bus.dropped_o    = dropped_q;
    assign bus.pace_count_o = pace_count_q;

endmodule
